// File: rtl/bus_master_if.sv
// CPU-side request/response and shared IO bus signals for the bus_master initiator.
interface bus_master_if #(
    parameter int unsigned ADDR_W = 30,
    parameter int unsigned DATA_W = 32
);
    logic              cpu_req;
    logic              cpu_rw;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wr_data;
    logic [DATA_W-1:0] cpu_rd_data;
    logic              cpu_busy;
    logic              cpu_done;
    logic              cpu_err;

    logic              bus_req_;
    logic              bus_grnt_;
    logic              bus_as_;
    logic              bus_rw;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wr_data;
    logic [DATA_W-1:0] bus_rd_data;
    logic              bus_rdy_;

    modport master (
        input  cpu_req, cpu_rw, cpu_addr, cpu_wr_data,
        output cpu_rd_data, cpu_busy, cpu_done, cpu_err,
        output bus_req_, bus_as_, bus_rw, bus_addr, bus_wr_data,
        input  bus_grnt_, bus_rd_data, bus_rdy_
    );

    modport slave (
        output cpu_req, cpu_rw, cpu_addr, cpu_wr_data,
        input  cpu_rd_data, cpu_busy, cpu_done, cpu_err,
        input  bus_req_, bus_as_, bus_rw, bus_addr, bus_wr_data,
        output bus_grnt_, bus_rd_data, bus_rdy_
    );
endinterface

// File: rtl/bus_master.sv
// Single-request IO bus initiator: arbitrate, one-cycle address strobe, wait for
// registered ready or timeout, then return data or error to the CPU.
module bus_master #(
    parameter int unsigned ADDR_W  = 30,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input logic          clk,
    input logic          reset,
    bus_master_if.master bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_ACCESS,
        S_WAIT
    } state_e;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_e            state_q, state_d;
    logic              rw_q, rw_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [7:0]        cnt_q, cnt_d;

    logic              bus_req_q, bus_req_d;
    logic              bus_as_q, bus_as_d;
    logic              bus_rw_q, bus_rw_d;
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic [DATA_W-1:0] bus_wr_data_q, bus_wr_data_d;

    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            rw_q          <= 1'b1;
            addr_q        <= '0;
            wdata_q       <= '0;
            cnt_q         <= '0;
            bus_req_q     <= 1'b1;
            bus_as_q      <= 1'b1;
            bus_rw_q      <= 1'b1;
            bus_addr_q    <= '0;
            bus_wr_data_q <= '0;
            rd_data_q     <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            rw_q          <= rw_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            cnt_q         <= cnt_d;
            bus_req_q     <= bus_req_d;
            bus_as_q      <= bus_as_d;
            bus_rw_q      <= bus_rw_d;
            bus_addr_q    <= bus_addr_d;
            bus_wr_data_q <= bus_wr_data_d;
            rd_data_q     <= rd_data_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            err_q         <= err_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        rw_d          = rw_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        cnt_d         = cnt_q;
        bus_req_d     = bus_req_q;
        bus_as_d      = bus_as_q;
        bus_rw_d      = bus_rw_q;
        bus_addr_d    = bus_addr_q;
        bus_wr_data_d = bus_wr_data_q;
        rd_data_d     = rd_data_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        err_d         = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.cpu_req) begin
                    rw_d      = bus.cpu_rw;
                    addr_d    = bus.cpu_addr;
                    wdata_d   = bus.cpu_wr_data;
                    bus_req_d = 1'b0;
                    busy_d    = 1'b1;
                    if (bus.cpu_rw) begin
                        rd_data_d = '0;
                    end
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                bus_req_d = 1'b0;
                if (!bus.bus_grnt_) begin
                    bus_as_d      = 1'b0;
                    bus_rw_d      = rw_q;
                    bus_addr_d    = addr_q;
                    bus_wr_data_d = wdata_q;
                    state_d       = S_ACCESS;
                end
            end
            S_ACCESS: begin
                // Ready is registered by the responder, so it is never valid here.
                bus_as_d      = 1'b1;
                bus_rw_d      = 1'b1;
                bus_addr_d    = '0;
                bus_wr_data_d = '0;
                cnt_d         = '0;
                state_d       = S_WAIT;
            end
            S_WAIT: begin
                if (!bus.bus_rdy_) begin
                    rd_data_d = rw_q ? bus.bus_rd_data : '0;
                    done_d    = 1'b1;
                    busy_d    = 1'b0;
                    bus_req_d = 1'b1;
                    state_d   = S_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    rd_data_d = '0;
                    done_d    = 1'b1;
                    err_d     = 1'b1;
                    busy_d    = 1'b0;
                    bus_req_d = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.cpu_rd_data = rd_data_q;
    assign bus.cpu_busy    = busy_q;
    assign bus.cpu_done    = done_q;
    assign bus.cpu_err     = err_q;
    assign bus.bus_req_    = bus_req_q;
    assign bus.bus_as_     = bus_as_q;
    assign bus.bus_rw      = bus_rw_q;
    assign bus.bus_addr    = bus_addr_q;
    assign bus.bus_wr_data = bus_wr_data_q;
endmodule

// File: tb/tb_bus_master.sv
// Directed bench for bus_master with a small registered responder model.
module tb_bus_master;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    bus_master_if #(.ADDR_W(30), .DATA_W(32)) bus ();

    bus_master #(.ADDR_W(30), .DATA_W(32), .TIMEOUT(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int          n_assert = 0;
    int          n_fail   = 0;
    int          n_strobe = 0;
    int          n_done   = 0;
    bit          mon_en   = 1'b0;
    int          resp_lat = 1;
    logic [31:0] resp_data = 32'h0;
    int          rcnt     = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_req_"}, bus.bus_req_, 1);
        chk({tag, "_as_"}, bus.bus_as_, 1);
        chk({tag, "_rw"}, bus.bus_rw, 1);
        chk({tag, "_addr"}, bus.bus_addr, 0);
        chk({tag, "_wdata"}, bus.bus_wr_data, 0);
        chk({tag, "_rdata"}, bus.cpu_rd_data, 0);
        chk({tag, "_busy"}, bus.cpu_busy, 0);
        chk({tag, "_done"}, bus.cpu_done, 0);
        chk({tag, "_err"}, bus.cpu_err, 0);
    endtask

    // Responder: ready goes low resp_lat cycles after the strobe edge; 0 = silent.
    always @(posedge clk) begin
        bus.bus_rdy_    <= 1'b1;
        bus.bus_rd_data <= '0;
        if (bus.bus_as_ === 1'b0 && resp_lat != 0) begin
            if (resp_lat == 1) begin
                bus.bus_rdy_    <= 1'b0;
                bus.bus_rd_data <= resp_data;
            end else begin
                rcnt <= resp_lat - 1;
            end
        end else if (rcnt > 0) begin
            rcnt <= rcnt - 1;
            if (rcnt == 1) begin
                bus.bus_rdy_    <= 1'b0;
                bus.bus_rd_data <= resp_data;
            end
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.bus_as_ === 1'b1) begin
                chk("idle_rw", bus.bus_rw, 1);
                chk("idle_addr", bus.bus_addr, 0);
                chk("idle_wdata", bus.bus_wr_data, 0);
            end else begin
                n_strobe++;
            end
            if (bus.cpu_done === 1'b1) n_done++;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset           = 1'b0;
        bus.cpu_req     = 1'b0;
        bus.cpu_rw      = 1'b1;
        bus.cpu_addr    = '0;
        bus.cpu_wr_data = '0;
        bus.bus_grnt_   = 1'b0;
        tick();
        tick();
        chk_reset_vals("rst");
        reset  = 1'b1;
        mon_en = 1'b1;

        // 1: single read, grant tied low
        resp_lat = 1; resp_data = 32'h0000_1234;
        bus.cpu_req = 1'b1; bus.cpu_rw = 1'b1; bus.cpu_addr = 30'h3;
        tick();
        chk("rd_req_low", bus.bus_req_, 0);
        chk("rd_busy", bus.cpu_busy, 1);
        chk("rd_as_e1", bus.bus_as_, 1);
        bus.cpu_req = 1'b0;
        tick();
        chk("rd_as_e2", bus.bus_as_, 0);
        chk("rd_bus_rw", bus.bus_rw, 1);
        chk("rd_bus_addr", bus.bus_addr, 30'h3);
        tick();
        chk("rd_as_e3", bus.bus_as_, 1);
        chk("rd_done_e3", bus.cpu_done, 0);
        tick();
        chk("rd_done", bus.cpu_done, 1);
        chk("rd_data", bus.cpu_rd_data, 32'h0000_1234);
        chk("rd_err", bus.cpu_err, 0);
        chk("rd_busy_done", bus.cpu_busy, 0);
        chk("rd_req_rel", bus.bus_req_, 1);
        tick();
        chk("rd_done_pulse", bus.cpu_done, 0);

        // 2: single write
        bus.cpu_req = 1'b1; bus.cpu_rw = 1'b0; bus.cpu_addr = 30'h2; bus.cpu_wr_data = 32'hFF;
        tick();
        bus.cpu_req = 1'b0;
        tick();
        chk("wr_as", bus.bus_as_, 0);
        chk("wr_bus_rw", bus.bus_rw, 0);
        chk("wr_bus_addr", bus.bus_addr, 30'h2);
        chk("wr_bus_wdata", bus.bus_wr_data, 32'hFF);
        tick();
        tick();
        chk("wr_done", bus.cpu_done, 1);
        chk("wr_rdata", bus.cpu_rd_data, 0);
        chk("wr_err", bus.cpu_err, 0);
        tick();

        // 3: grant delayed 5 cycles after bus_req_ falls
        bus.bus_grnt_ = 1'b1; resp_data = 32'h0000_ABCD;
        bus.cpu_req = 1'b1; bus.cpu_rw = 1'b1; bus.cpu_addr = 30'h5;
        tick();
        chk("dg_req_low", bus.bus_req_, 0);
        bus.cpu_req = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("dg_no_strobe", bus.bus_as_, 1);
            chk("dg_req_held", bus.bus_req_, 0);
        end
        bus.bus_grnt_ = 1'b0;
        tick();
        chk("dg_as", bus.bus_as_, 0);
        tick();
        chk("dg_done_e8", bus.cpu_done, 0);
        tick();
        chk("dg_done", bus.cpu_done, 1);
        chk("dg_data", bus.cpu_rd_data, 32'h0000_ABCD);
        chk("dg_req_rel", bus.bus_req_, 1);
        tick();

        // 4a: timeout with silent responder (TIMEOUT=4)
        resp_lat = 0;
        bus.cpu_req = 1'b1; bus.cpu_rw = 1'b1; bus.cpu_addr = 30'h7;
        tick();
        bus.cpu_req = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("to_wait_done", bus.cpu_done, 0);
            chk("to_wait_busy", bus.cpu_busy, 1);
        end
        tick();
        chk("to_done", bus.cpu_done, 1);
        chk("to_err", bus.cpu_err, 1);
        chk("to_rdata", bus.cpu_rd_data, 0);
        chk("to_req_rel", bus.bus_req_, 1);
        chk("to_busy", bus.cpu_busy, 0);
        tick();
        chk("to_done_pulse", bus.cpu_done, 0);
        chk("to_err_pulse", bus.cpu_err, 0);

        // 4b: ready on the final allowed WAIT cycle
        resp_lat = 4; resp_data = 32'h0000_55AA;
        bus.cpu_req = 1'b1;
        tick();
        bus.cpu_req = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("lr_done_e6", bus.cpu_done, 0);
        tick();
        chk("lr_done", bus.cpu_done, 1);
        chk("lr_err", bus.cpu_err, 0);
        chk("lr_data", bus.cpu_rd_data, 32'h0000_55AA);
        tick();

        // 5: reset during WAIT
        resp_lat = 0;
        bus.cpu_req = 1'b1;
        tick();
        bus.cpu_req = 1'b0;
        tick();
        tick();
        tick();
        chk("mr_busy_pre", bus.cpu_busy, 1);
        reset = 1'b0;
        tick();
        chk_reset_vals("mr");
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("mr_no_done", bus.cpu_done, 0);
            chk("mr_bus_idle", bus.bus_req_, 1);
        end
        resp_lat = 1; resp_data = 32'h0000_0077;
        bus.cpu_req = 1'b1; bus.cpu_addr = 30'h9;
        tick();
        bus.cpu_req = 1'b0;
        tick();
        tick();
        tick();
        chk("mr_fresh_done", bus.cpu_done, 1);
        chk("mr_fresh_data", bus.cpu_rd_data, 32'h0000_0077);
        chk("mr_fresh_err", bus.cpu_err, 0);
        tick();

        // 6: cpu_req held high, back-to-back transactions
        resp_data = 32'h0000_0099;
        n_strobe = 0;
        n_done   = 0;
        bus.cpu_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bb_req_low", bus.bus_req_, 0);
            chk("bb_busy", bus.cpu_busy, 1);
            tick();
            tick();
            tick();
            chk("bb_done", bus.cpu_done, 1);
            chk("bb_req_rel", bus.bus_req_, 1);
            chk("bb_data", bus.cpu_rd_data, 32'h0000_0099);
        end
        bus.cpu_req = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("bb_strobes", n_strobe, 5);
        chk("bb_dones", n_done, 5);
        chk("bb_final_idle", bus.bus_req_, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
